// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_controller_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StMdBusy = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlRun   = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam pipe_ctrl_t CtrlStall = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam pipe_ctrl_t CtrlFlush = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam pipe_ctrl_t CtrlReset = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       if_id_flush: 1'b1, id_ex_bubble: 1'b1};

endpackage

// File: rtl/hazard_stall_controller_muldiv_busy_timer.sv
// Busy timer for the multi-cycle mult/div unit: two-state FSM plus down-counter.
module muldiv_busy_timer
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o,
  output logic last_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_o  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (start_i) begin
          state_d = StMdBusy;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      StMdBusy: begin
        // A start here is unreachable: decode stalls any HI/LO user while busy.
        if (cnt_q == CNT_W'(1)) begin
          last_o  = 1'b1;
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline advance sequencer: load-use and HI/LO stalls, taken-branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_UsesRt,
  input  logic        IF_ID_UsesHiLo,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MulDivStart,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
`ifdef HAZARD_PERF_EN
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
`endif
  output logic        MulDivBusy
);

  logic       md_busy;
  logic       md_last;
  logic       lu_haz;
  logic       md_haz;
  logic       stall;
  pipe_ctrl_t ctrl;

  muldiv_busy_timer #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (ID_EX_MulDivStart),
    .busy_o  (md_busy),
    .last_o  (md_last)
  );

  always_comb begin
    lu_haz = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) &&
             ((ID_EX_rt == IF_ID_rs) || (IF_ID_UsesRt && (ID_EX_rt == IF_ID_rt)));
    md_haz = IF_ID_UsesHiLo && (md_busy || ID_EX_MulDivStart);
    stall  = lu_haz || md_haz;
  end

  always_comb begin
    ctrl = CtrlRun;
    if (Reset) begin
      ctrl = CtrlReset;
    end else if (EX_BranchTaken) begin
      ctrl = CtrlFlush;
    end else if (stall) begin
      ctrl = CtrlStall;
    end
  end

  assign PCWrite      = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign ID_EX_Bubble = ctrl.id_ex_bubble;
  assign MulDivBusy   = md_busy && !Reset;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A branch overrides a pending stall, so that cycle counts as a flush only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (EX_BranchTaken) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

  // The final busy cycle is always flagged from within the busy state.
  a_last_in_busy : assert property (@(posedge Clk) disable iff (Reset) md_last |-> md_busy);
  a_no_start_busy : assert property (@(posedge Clk) disable iff (Reset)
                                     md_busy |-> !ID_EX_MulDivStart);

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus randomized run.
module tb_hazard_stall_controller;

  localparam int unsigned MulDivLat = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_rs, if_rt, ex_rt;
  logic       uses_rt, uses_hilo, mem_read, md_start, br_taken;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [4:0] obs;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MULDIV_LAT (MulDivLat),
    .CNT_W      (3)
  ) dut (
    .Clk               (clk),
    .Reset             (rst),
    .IF_ID_rs          (if_rs),
    .IF_ID_rt          (if_rt),
    .IF_ID_UsesRt      (uses_rt),
    .IF_ID_UsesHiLo    (uses_hilo),
    .ID_EX_rt          (ex_rt),
    .ID_EX_MemRead     (mem_read),
    .ID_EX_MulDivStart (md_start),
    .EX_BranchTaken    (br_taken),
    .PCWrite           (pc_write),
    .IF_ID_Write       (if_id_write),
    .IF_ID_Flush       (if_id_flush),
    .ID_EX_Bubble      (id_ex_bubble),
`ifdef HAZARD_PERF_EN
    .StallCycles       (stall_cycles),
    .FlushCount        (flush_count),
`endif
    .MulDivBusy        (md_busy)
  );

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivBusy}
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy};

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic hl, input logic [4:0] xrt, input logic mr,
                       input logic st, input logic br);
    if_rs = rs; if_rt = rt; uses_rt = urt; uses_hilo = hl;
    ex_rt = xrt; mem_read = mr; md_start = st; br_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (obs !== 5'b00110) $display("FAIL reset_outputs: got %b expected %b", obs, 5'b00110);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL reset_release: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b00010) $display("FAIL lu_stall_rs: got %b expected %b", obs, 5'b00010);
    else n_pass++;
    tick();
    drive(5'd8, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL lu_one_cycle: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use_cases();
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL lu_reg_zero: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
    drive(5'd3, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b00010) $display("FAIL lu_rt_used: got %b expected %b", obs, 5'b00010);
    else n_pass++;
    tick();
    drive(5'd3, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL lu_rt_unused: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_muldiv();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b00010) $display("FAIL md_issue_stall: got %b expected %b", obs, 5'b00010);
    else n_pass++;
    tick();
    for (int i = 1; i < MulDivLat; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (obs !== 5'b00011) $display("FAIL md_busy_stall[%0d]: got %b expected %b", i, obs,
                                     5'b00011);
      else n_pass++;
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL md_release: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch();
    drive(5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (obs !== 5'b11110) $display("FAIL branch_over_lu: got %b expected %b", obs, 5'b11110);
    else n_pass++;
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL branch_after: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b11001) $display("FAIL busy_before_rst: got %b expected %b", obs, 5'b11001);
    else n_pass++;
    tick();
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== 5'b00110) $display("FAIL rst_mid_busy: got %b expected %b", obs, 5'b00110);
    else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b11000) $display("FAIL run_after_rst: got %b expected %b", obs, 5'b11000);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int          busy_left;
    int unsigned exp_stall, exp_flush;
    logic        lu, md, stall_c;
    logic [4:0]  exp;
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    busy_left = 0;
    exp_stall = 0;
    exp_flush = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            (busy_left == 0) && ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      lu = mem_read && (ex_rt != 5'd0) && (ex_rt == if_rs || (uses_rt && ex_rt == if_rt));
      md = uses_hilo && (busy_left > 0 || md_start);
      stall_c = lu || md;
      if (rst) exp = 5'b00110;
      else if (br_taken) exp = {4'b1111, busy_left > 0};
      else if (stall_c) exp = {4'b0001, busy_left > 0};
      else exp = {4'b1100, busy_left > 0};
      #1;
      n_checks++;
      if (obs !== exp) $display("FAIL random_out[%0d]: got %b expected %b", n, obs, exp);
      else n_pass++;
      if (rst) begin
        busy_left = 0;
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (busy_left > 0) busy_left--;
        else if (md_start) busy_left = MulDivLat - 1;
        if (br_taken) exp_flush++;
        else if (stall_c) exp_stall++;
      end
      tick();
`ifdef HAZARD_PERF_EN
      n_checks++;
      if (stall_cycles !== exp_stall || flush_count !== exp_flush)
        $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", n, stall_cycles,
                 flush_count, exp_stall, exp_flush);
      else n_pass++;
`endif
    end
    rst = 1'b0;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    test_load_use();
    test_muldiv();
    test_branch();
    n_checks++;
    if (stall_cycles !== 32'd5) $display("FAIL perf_stalls: got %0d expected 5", stall_cycles);
    else n_pass++;
    n_checks++;
    if (flush_count !== 32'd1) $display("FAIL perf_flushes: got %0d expected 1", flush_count);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_load_use_cases();
    test_muldiv();
    test_branch();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
